// File: rtl/counter_ctrl.sv
// Interval-timer sequencer for an external free-running counter: start/stop, prescaled advance,
// terminal-count detection, one-shot/periodic. Optional sticky IRQ with `COUNTER_CTRL_IRQ_EN.
module counter_ctrl #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic              MODE,
    input  logic [DWIDTH-1:0] TC,
    input  logic [PWIDTH-1:0] PRESC,
    input  logic [DWIDTH-1:0] CNT_Q,
    output logic              CNT_CE,
    output logic              CNT_SCLR,
    output logic              READY,
    output logic              BUSY,
    output logic              DONE,
`ifdef COUNTER_CTRL_IRQ_EN
    input  logic              IRQ_CLR,
    output logic              IRQ,
`endif
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state;
    logic [DWIDTH-1:0] tc_r;
    logic [PWIDTH-1:0] presc_r;
    logic              mode_r;
    logic [PWIDTH-1:0] pc;
    logic              tick;
    logic              term;

    // Handshake: a start is taken at a rising edge where START && READY; there is no
    // queueing, so START while busy is dropped. STOP only acts while BUSY and beats
    // both the terminal tick and the clear cycle.
    assign READY     = (state == IDLE) && !RST;
    assign BUSY      = (state != IDLE);
    assign state_dbg = state;

    assign tick = (state == RUN) && (pc == presc_r);
    // >= so that a stale or corrupted counter value still terminates the interval
    assign term = tick && (CNT_Q >= tc_r);

    // The counter only honours SCLR when CE is high, so every clear drives both.
    always_comb begin
        CNT_CE   = 1'b0;
        CNT_SCLR = 1'b0;
        if (!RST && !(BUSY && STOP)) begin
            case (state)
                CLEAR: begin
                    CNT_CE   = 1'b1;
                    CNT_SCLR = 1'b1;
                end
                RUN: begin
                    CNT_CE   = tick && !(term && !mode_r);
                    CNT_SCLR = term && mode_r;
                end
                default: begin
                    CNT_CE   = 1'b0;
                    CNT_SCLR = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            tc_r    <= '0;
            presc_r <= '0;
            mode_r  <= 1'b0;
            pc      <= '0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        tc_r    <= TC;
                        presc_r <= PRESC;
                        mode_r  <= MODE;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    pc    <= '0;
                    state <= STOP ? IDLE : RUN;
                end
                RUN: begin
                    if (STOP) begin
                        state <= IDLE;
                    end else if (term) begin
                        DONE <= 1'b1;
                        pc   <= '0;
                        if (!mode_r) state <= IDLE;
                    end else if (tick) begin
                        pc <= '0;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COUNTER_CTRL_IRQ_EN
    // Sticky interrupt; a completing interval wins over a coincident clear.
    always_ff @(posedge CLK) begin
        if (RST)          IRQ <= 1'b0;
        else if (DONE)    IRQ <= 1'b1;
        else if (IRQ_CLR) IRQ <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: a behavioural counter closes the loop; a vector table covers
// one-shot/periodic timing, hand sequences cover stop, reset, restart and IRQ corners.
module tb_counter_ctrl;

    typedef struct {
        logic       mode;
        logic [7:0] tc;
        logic [7:0] presc;
        int         first_done;
        int         period;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start, stop, mode;
    logic [7:0] tc, presc;
    logic [7:0] cnt_q = 8'd0;
    logic       cnt_ce, cnt_sclr, ready, busy, done;
    logic [1:0] state_dbg;
`ifdef COUNTER_CTRL_IRQ_EN
    logic       irq_clr, irq;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[8];

    counter_ctrl #(.DWIDTH(8), .PWIDTH(8)) dut (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop), .MODE(mode),
        .TC(tc), .PRESC(presc), .CNT_Q(cnt_q),
        .CNT_CE(cnt_ce), .CNT_SCLR(cnt_sclr), .READY(ready), .BUSY(busy), .DONE(done),
`ifdef COUNTER_CTRL_IRQ_EN
        .IRQ_CLR(irq_clr), .IRQ(irq),
`endif
        .state_dbg(state_dbg)
    );

    // clock / reset-independent environment: the external counter
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_ce) cnt_q <= cnt_sclr ? 8'd0 : cnt_q + 8'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [7:0] t, input logic [7:0] p);
        check("ready before start", ready, 1);
        start = 1'b1; mode = m; tc = t; presc = p;
        step();
        start = 1'b0;
        check("clear ce", cnt_ce, 1);
        check("clear sclr", cnt_sclr, 1);
        check("busy in clear", busy, 1);
        check("state clear", state_dbg, 1);
    endtask

    // Steps at least once; returns the number of edges taken until DONE is seen.
    task automatic wait_done(input int max, input logic [7:0] limit, output int k);
        logic [7:0] e;
        k = 0;
        do begin
            step();
            k++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cnt_q sequence", cnt_q, e);
            end
            check("cnt_q within tc", cnt_q <= limit, 1);
        end while (!done && k < max);
        if (!done) check("done timeout", done, 1);
    endtask

    initial begin
        int   k;
        vec_t v;

        vecs[0] = '{1'b0, 8'd3,   8'd0, 5,   0};
        vecs[1] = '{1'b1, 8'd2,   8'd1, 7,   6};
        vecs[2] = '{1'b0, 8'd0,   8'd0, 2,   0};
        vecs[3] = '{1'b1, 8'd0,   8'd0, 2,   1};
        vecs[4] = '{1'b0, 8'd5,   8'd2, 19,  0};
        vecs[5] = '{1'b1, 8'd4,   8'd0, 6,   5};
        vecs[6] = '{1'b0, 8'd255, 8'd0, 257, 0};
        vecs[7] = '{1'b1, 8'd1,   8'd3, 9,   8};

        // reset, with a START held during it that must be ignored
        rst = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b0; tc = 8'd0; presc = 8'd0;
`ifdef COUNTER_CTRL_IRQ_EN
        irq_clr = 1'b0;
`endif
        step();
        step();
        check("reset ce", cnt_ce, 0);
        check("reset sclr", cnt_sclr, 0);
        check("reset busy", busy, 0);
        check("reset ready", ready, 0);
        check("reset done", done, 0);
        check("reset state", state_dbg, 0);
`ifdef COUNTER_CTRL_IRQ_EN
        check("reset irq", irq, 0);
`endif
        rst = 1'b0; start = 1'b0;
        #1;
        check("ready after reset", ready, 1);
        step();

        // table-driven runs
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            for (int j = 1; j < v.first_done; j++) exp_q.push_back(8'((j - 1) / (v.presc + 1)));
            do_start(v.mode, v.tc, v.presc);
            wait_done(v.first_done + 10, v.tc, k);
            check("first done edge", k, v.first_done);
            exp_q.delete();
            if (!v.mode) begin
                check("oneshot ready in done", ready, 1);
                check("oneshot busy in done", busy, 0);
                check("oneshot q at done", cnt_q, v.tc);
                step();
                check("oneshot single pulse", done, 0);
                check("oneshot q holds", cnt_q, v.tc);
            end else begin
                check("periodic q at done", cnt_q, 0);
                repeat (2) begin
                    for (int j = 1; j < v.period; j++) exp_q.push_back(8'(j / (v.presc + 1)));
                    wait_done(v.period + 10, v.tc, k);
                    check("periodic interval", k, v.period);
                    exp_q.delete();
                end
                stop = 1'b1;
                #1;
                check("stop ce low", cnt_ce, 0);
                step();
                stop = 1'b0;
                check("stop idle", busy, 0);
                check("stop no done", done, 0);
            end
        end

        // STOP in CLEAR
        do_start(1'b0, 8'd3, 8'd0);
        stop = 1'b1;
        #1;
        check("stop in clear ce", cnt_ce, 0);
        check("stop in clear sclr", cnt_sclr, 0);
        step();
        stop = 1'b0;
        check("stop in clear idle", state_dbg, 0);
        check("stop in clear ready", ready, 1);
        repeat (6) begin
            step();
            check("stop in clear no done", done, 0);
        end

        // STOP in the terminal-tick cycle of a periodic run
        do_start(1'b1, 8'd3, 8'd0);
        repeat (4) step();
        check("term cycle q", cnt_q, 3);
        check("term cycle ce", cnt_ce, 1);
        check("term cycle sclr", cnt_sclr, 1);
        stop = 1'b1;
        #1;
        check("stop at term ce", cnt_ce, 0);
        check("stop at term sclr", cnt_sclr, 0);
        step();
        stop = 1'b0;
        check("stop at term idle", state_dbg, 0);
        check("stop at term no done", done, 0);
        check("stop at term q held", cnt_q, 3);
        step();
        check("stop at term still no done", done, 0);

        // START in the DONE cycle of a one-shot is accepted
        do_start(1'b0, 8'd0, 8'd0);
        wait_done(10, 8'd0, k);
        check("tc0 done edge", k, 2);
        do_start(1'b0, 8'd1, 8'd0);
        wait_done(10, 8'd1, k);
        check("back-to-back done edge", k, 3);
        step();

        // START during RUN is ignored
        do_start(1'b1, 8'd2, 8'd1);
        wait_done(20, 8'd2, k);
        check("run first done", k, 7);
        step();
        start = 1'b1; mode = 1'b0; tc = 8'd0; presc = 8'd0;
        #1;
        check("ready low in run", ready, 0);
        step();
        start = 1'b0;
        check("still running", state_dbg, 2);
        wait_done(20, 8'd2, k);
        check("period unchanged", k + 2, 6);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // reset mid-RUN
        do_start(1'b0, 8'd200, 8'd0);
        repeat (50) step();
        check("mid-run q", cnt_q, 49);
        rst = 1'b1;
        #1;
        check("rst ce", cnt_ce, 0);
        check("rst ready", ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("rst idle", state_dbg, 0);
        check("rst busy", busy, 0);
        check("rst ready back", ready, 1);
        check("rst q untouched", cnt_q, 49);
        repeat (5) begin
            step();
            check("rst no done", done, 0);
        end
        exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
        do_start(1'b0, 8'd2, 8'd0);
        wait_done(10, 8'd2, k);
        check("restart done edge", k, 4);
        exp_q.delete();
        step();

`ifdef COUNTER_CTRL_IRQ_EN
        do_start(1'b1, 8'd1, 8'd0);
        wait_done(10, 8'd1, k);
        check("irq run first done", k, 3);
        check("irq low before set", irq, 0);
        step();
        check("irq set", irq, 1);
        check("irq gap done", done, 0);
        step();
        check("irq second done", done, 1);
        step();
        check("irq sticky", irq, 1);
        check("irq gap done 2", done, 0);
        irq_clr = 1'b1;
        step();
        check("irq cleared", irq, 0);
        check("irq third done", done, 1);
        step();
        irq_clr = 1'b0;
        check("irq set wins", irq, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencing controller for the team's free-running binary counter. It drives the counter's `CE`/`SCLR` inputs and watches its `Q` output to form a programmable interval timer: start/stop handshake, prescaled advance, terminal-count detection, and one-shot or periodic operation. It sits between the control logic (or a register interface) and one counter instance of matching `DWIDTH`. That counter's own asynchronous reset stays wired separately by the integrator.

## Interface
- `DWIDTH`, 8: width of the counter value and terminal count.
- `PWIDTH`, 8: width of the prescaler.

- `CLK`  in  1  clock.
- `RST`  in  1  reset, synchronous, active-high.
- `START`  in  1  start request; accepted only when `START && READY` at a rising edge.
- `STOP`  in  1  abort; effective only while `BUSY`.
- `MODE`  in  1  0 = one-shot, 1 = periodic; sampled at start accept.
- `TC`  in  DWIDTH  terminal count; sampled at start accept.
- `PRESC`  in  PWIDTH  counter advances once every `PRESC+1` cycles; sampled at start accept.
- `CNT_Q`  in  DWIDTH  counter `Q`.
- `CNT_CE`  out  1  counter enable.
- `CNT_SCLR`  out  1  counter synchronous clear.
- `READY`  out  1  idle, can accept `START`.
- `BUSY`  out  1  `state != IDLE`.
- `DONE`  out  1  one-cycle pulse per completed interval.

## Operation
- Registers:
  - FSM state, with states IDLE, CLEAR and RUN.
  - `tc_r`, `presc_r`, `mode_r`.
  - Prescale counter `pc` (PWIDTH bits).
  - `DONE`.
- Counter outputs:
  - `CNT_CE` and `CNT_SCLR` are combinational from state and registers.
  - Both are forced to 0 while `RST` is high.
  - The counter acts on `SCLR` only when `CE` is high, so every clear asserts both.
- `READY = (state==IDLE) && !RST`.
- Tick: in RUN, `tick = (pc == presc_r)`.
- Terminal: `term = tick && (CNT_Q >= tc_r)`. The `>=` comparison tolerates a stale or corrupted counter value.
- IDLE:
  - `CNT_CE=0`.
  - On `START`: latch `TC`, `PRESC`, `MODE`, then go to CLEAR.
  - `STOP` is ignored.
- CLEAR:
  - `CNT_CE=1`, `CNT_SCLR=1` for exactly one cycle.
  - `pc<=0`, then go to RUN.
- RUN:
  - No tick: `pc<=pc+1`, `CNT_CE=0`.
  - Tick without term: `pc<=0`, `CNT_CE=1`, `CNT_SCLR=0` (counter increments).
  - Term, one-shot: `CNT_CE=0`, `DONE<=1`, go to IDLE. Counter holds `tc_r`.
  - Term, periodic: `CNT_CE=1`, `CNT_SCLR=1`, `pc<=0`, `DONE<=1`, stay in RUN.
- `STOP` while BUSY:
  - Next state is IDLE.
  - `CNT_CE=0` in that cycle.
  - No `DONE`.
  - `STOP` has priority over term and over the CLEAR action.
- `START` while BUSY is ignored; there is no queueing.
- `START` and `STOP` together in IDLE: start is accepted.
- `TC=0` is legal: term occurs on the first tick.
- `TC=2^DWIDTH-1` is legal: the counter never wraps, because term clears or halts it first.
- `PRESC=0`: a tick every RUN cycle.

## Timing
- Start accept at edge E0.
  - CLEAR occupies cycle E0–E1.
  - At E1, `CNT_Q=0`.
- `DONE` is registered. It is high for the single cycle following the terminal-tick edge.
- First `DONE` rises at E0 + `(TC+1)*(PRESC+1)+1` edges.
- Periodic mode:
  - Subsequent `DONE`s occur every `(TC+1)*(PRESC+1)` cycles.
  - `CNT_Q` sequence is 0..TC repeating.
- One-shot: `READY` rises in the same cycle `DONE` is high, so back-to-back `START` is accepted at the edge ending the `DONE` cycle.
- Reset:
  - At the edge with `RST` high: state IDLE, `DONE=0`, `pc=0`, `tc_r/presc_r/mode_r=0`.
  - Outputs during and after reset: `CNT_CE=0`, `CNT_SCLR=0`, `BUSY=0`, `READY=1` once `RST` is low.
  - Reset mid-RUN leaves the counter value untouched. The next start clears it.

## Configuration
- `COUNTER_CTRL_IRQ_EN` defined:
  - Adds input `IRQ_CLR` (1) and output `IRQ` (1).
  - `IRQ` is sticky. It is set on each cycle `DONE` is high and cleared by `IRQ_CLR`.
  - Set wins over a simultaneous clear.
  - `IRQ` resets to 0.
- Undefined: the ports and the logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `START`, `MODE=0`, `TC=3`, `PRESC=0` → `CNT_Q` 0,1,2,3; single `DONE` 5 edges after accept; `READY` back; `CNT_Q` holds 3.
- `MODE=1`, `TC=2`, `PRESC=1` → `DONE` every 6 cycles, first at accept+7; `CNT_Q` 0,0,1,1,2,2 repeating; no value above 2.
- `STOP` asserted in CLEAR, and separately in the terminal-tick cycle → IDLE next edge, no `DONE`, `CNT_CE` low that cycle.
- `TC=0`, `PRESC=0`, one-shot → `DONE` at accept+2. `START` in the `DONE` cycle is accepted. `START` during RUN is ignored, with no period change.
- `RST` pulsed mid-RUN, `TC=200` → next edge IDLE, `CNT_CE=0`, `DONE` never pulses; restart counts from 0.
- With `COUNTER_CTRL_IRQ_EN`: periodic run → `IRQ` stays high across `DONE`s. `IRQ_CLR` alone clears it. `IRQ_CLR` coincident with `DONE` leaves it set.
